// File: rtl/dealer_pkg.sv
// dealer_pkg: shared constants, FSM state type and rank decoding for the card dealer.
package dealer_pkg;

    localparam int NUM_RANKS      = 13;
    localparam int CARDS_PER_DECK = 52;

    // Feedback taps q[15], q[13], q[12], q[10]: maximal-length 16-bit sequence.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        FILL_P,
        FILL_D,
        SHUFFLE
    } state_e;

    // Ace counts as 1, pip cards as face value, J/Q/K as 10.
    function automatic logic [4:0] rank_to_value(input logic [3:0] rank);
        return (rank == 4'd0) ? 5'd1 : (rank <= 4'd9) ? {1'b0, rank} + 5'd1 : 5'd10;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR with a synchronised entropy bit mixed into feedback.
//   clock     : system clock
//   reset_n   : synchronous active-low reset, loads SEED (0 is replaced by 1)
//   entropy_i : asynchronous raw bit, double-flopped before use
//   state_o   : current LFSR value
module lfsr16
    import dealer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        entropy_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [1:0]  sync_q;
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS) ^ sync_q[1]};
    assign state_o = lfsr_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
            lfsr_q <= SEED_EFF;
        end else begin
            sync_q <= {sync_q[0], entropy_i};
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: keeps one pre-drawn card per slot, drawn without replacement from a DECKS-deck shoe.
//   clock      : system clock
//   reset_n    : synchronous active-low reset
//   take_p     : pulse, player card consumed; refill player slot
//   take_d     : pulse, dealer card consumed; refill dealer slot
//   entropy    : raw asynchronous bit stirred into the LFSR
//   pcard      : player card value 1..10, 0 while pvalid=0
//   dcard      : dealer card value 1..10, 0 while dvalid=0
//   pvalid     : player slot holds a card
//   dvalid     : dealer slot holds a card
//   cards_left : cards remaining in the shoe, excluding both slots
//   reshuffled : one-cycle pulse when the shoe is refilled
module card_dealer
    import dealer_pkg::*;
#(
    parameter int          DECKS     = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       take_p,
    input  logic       take_d,
    input  logic       entropy,
    output logic [4:0] pcard,
    output logic [4:0] dcard,
    output logic       pvalid,
    output logic       dvalid,
    output logic [7:0] cards_left,
    output logic       reshuffled
);

    localparam logic [3:0] RANK_FULL = 4'(4 * DECKS);
    localparam logic [7:0] SHOE_FULL = 8'(CARDS_PER_DECK * DECKS);

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic [3:0]  cnt_q [NUM_RANKS];
    logic [3:0]  cnt_d [NUM_RANKS];
    logic [7:0]  left_q, left_d;
    logic [4:0]  pcard_q, pcard_d, dcard_q, dcard_d;
    logic        pvalid_q, pvalid_d, dvalid_q, dvalid_d;
    logic        resh_q, resh_d;
    logic        pend_p_q, pend_p_d, pend_d_q, pend_d_d;
    logic [15:0] lfsr;
    logic [3:0]  rank;
    logic        rank_ok;
    logic        unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock     (clock),
        .reset_n   (reset_n),
        .entropy_i (entropy),
        .state_o   (lfsr)
    );

    assign rank        = lfsr[3:0];
    assign unused_lfsr = ^lfsr[15:4];
    // Ranks 13..15 and exhausted ranks are rejected; the next cycle offers a new candidate.
    assign rank_ok     = (rank < 4'(NUM_RANKS)) && (cnt_q[rank] != 4'd0);

    assign pcard      = pcard_q;
    assign dcard      = dcard_q;
    assign pvalid     = pvalid_q;
    assign dvalid     = dvalid_q;
    assign cards_left = left_q;
    assign reshuffled = resh_q;

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        pcard_d  = pcard_q;
        dcard_d  = dcard_q;
        pvalid_d = pvalid_q;
        dvalid_d = dvalid_q;
        resh_d   = 1'b0;
        // A take only counts against a slot that currently holds a card.
        pend_p_d = pend_p_q | (take_p & pvalid_q);
        pend_d_d = pend_d_q | (take_d & dvalid_q);
        case (state_q)
            IDLE: begin
                if (pend_p_d) begin
                    pvalid_d = 1'b0;
                    pcard_d  = 5'd0;
                end
                if (pend_d_d) begin
                    dvalid_d = 1'b0;
                    dcard_d  = 5'd0;
                end
                state_d  = pend_p_d ? FILL_P : (pend_d_d ? FILL_D : IDLE);
                pend_p_d = 1'b0;
                pend_d_d = 1'b0;
            end
            FILL_P, FILL_D: begin
                if (left_q == 8'd0) begin
                    state_d = SHUFFLE;
                    ret_d   = state_q;
                end else if (rank_ok) begin
                    cnt_d[rank] = cnt_q[rank] - 4'd1;
                    left_d      = left_q - 8'd1;
                    if (state_q == FILL_P) begin
                        pcard_d  = rank_to_value(rank);
                        pvalid_d = 1'b1;
                        state_d  = dvalid_q ? IDLE : FILL_D;
                    end else begin
                        dcard_d  = rank_to_value(rank);
                        dvalid_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            SHUFFLE: begin
                // Slot cards stay out of play but are not subtracted from the fresh shoe.
                for (int i = 0; i < NUM_RANKS; i++) cnt_d[i] = RANK_FULL;
                left_d  = SHOE_FULL;
                resh_d  = 1'b1;
                state_d = ret_q;
            end
            default: state_d = FILL_P;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= FILL_P;
            ret_q    <= FILL_P;
            for (int i = 0; i < NUM_RANKS; i++) cnt_q[i] <= RANK_FULL;
            left_q   <= SHOE_FULL;
            pcard_q  <= 5'd0;
            dcard_q  <= 5'd0;
            pvalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            resh_q   <= 1'b0;
            pend_p_q <= 1'b0;
            pend_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            pcard_q  <= pcard_d;
            dcard_q  <= dcard_d;
            pvalid_q <= pvalid_d;
            dvalid_q <= dvalid_d;
            resh_q   <= resh_d;
            pend_p_q <= pend_p_d;
            pend_d_q <= pend_d_d;
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench for card_dealer against a value-level shoe model.
module tb_card_dealer;

    localparam int          D    = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clock = 1'b0, reset_n = 1'b0, take_p = 1'b0, take_d = 1'b0, entropy = 1'b0;
    logic [4:0] pcard, dcard;
    logic       pvalid, dvalid, reshuffled;
    logic [7:0] cards_left;

    card_dealer #(.DECKS(D), .LFSR_SEED(SEED)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .take_p     (take_p),
        .take_d     (take_d),
        .entropy    (entropy),
        .pcard      (pcard),
        .dcard      (dcard),
        .pvalid     (pvalid),
        .dvalid     (dvalid),
        .cards_left (cards_left),
        .reshuffled (reshuffled)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0;
    int exp_q[$];
    int mcnt[11];
    int hist[11];
    int mleft, resh_cnt = 0, accepts = 0;
    logic       pv_prev = 1'b0, dv_prev = 1'b0;
    logic [4:0] pc_prev = 5'd0, dc_prev = 5'd0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 1; v <= 10; v++) mcnt[v] = (v == 10) ? 16 * D : 4 * D;
        mleft = 52 * D;
    endfunction

    task automatic accept(input int slot, input int val);
        int idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i] == slot) idx = i;
        chk(slot ? "fill_expected_d" : "fill_expected_p", int'(idx >= 0), 1);
        if (idx >= 0) exp_q.delete(idx);
        chk("card_range", int'(val >= 1 && val <= 10), 1);
        if (val >= 1 && val <= 10) begin
            chk("card_in_shoe", int'(mcnt[val] > 0), 1);
            mcnt[val]--;
            hist[val]++;
        end
        mleft--;
        accepts++;
        chk("cards_left", cards_left, mleft);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (reshuffled) begin
                resh_cnt++;
                chk("shuffle_when_empty", mleft, 0);
                chk("shuffle_left", cards_left, 52 * D);
                model_reset();
            end
            if (pvalid && !pv_prev) accept(0, pcard);
            if (dvalid && !dv_prev) accept(1, dcard);
            if (pvalid && pv_prev) chk("pcard_stable", pcard, pc_prev);
            if (dvalid && dv_prev) chk("dcard_stable", dcard, dc_prev);
            if (!pvalid) chk("pcard_zero", pcard, 0);
            if (!dvalid) chk("dcard_zero", dcard, 0);
            pv_prev = pvalid;
            dv_prev = dvalid;
            pc_prev = pcard;
            dc_prev = dcard;
        end else begin
            pv_prev = 1'b0;
            dv_prev = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset(input int n, input logic with_take);
        reset_n = 1'b0;
        take_p  = with_take;
        exp_q.delete();
        model_reset();
        for (int v = 0; v <= 10; v++) hist[v] = 0;
        resh_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            take_p = 1'b0;
            chk("reset_pvalid", pvalid, 0);
            chk("reset_dvalid", dvalid, 0);
            chk("reset_left", cards_left, 52 * D);
            chk("reset_pcard", pcard, 0);
            chk("reset_resh", reshuffled, 0);
        end
        exp_q.push_back(0);
        exp_q.push_back(1);
        reset_n = 1'b1;
    endtask

    // Expected first two cards and their latencies, straight from the LFSR sequence.
    task automatic check_first_draw();
        logic [15:0] x;
        int r, found, tp, td, pv, dv;
        int k[2], v[2];
        x = (SEED == 16'h0000) ? 16'h0001 : SEED;
        found = 0;
        k[0] = 0; k[1] = 0; v[0] = 0; v[1] = 0;
        for (int i = 0; i < 64 && found < 2; i++) begin
            r = int'(x[3:0]);
            if (r < 13) begin
                k[found] = i;
                v[found] = (r == 0) ? 1 : (r < 10 ? r + 1 : 10);
                found++;
            end
            x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
        end
        tp = -1; td = -1; pv = 0; dv = 0;
        for (int t = 1; t <= 64 && td < 0; t++) begin
            tick();
            if (pvalid && tp < 0) begin tp = t; pv = int'(pcard); end
            if (dvalid && td < 0) begin td = t; dv = int'(dcard); end
        end
        chk("first_p_latency", tp, k[0] + 1);
        chk("first_d_latency", td, k[1] + 1);
        chk("first_pcard", pv, v[0]);
        chk("first_dcard", dv, v[1]);
        chk("left_after_first", cards_left, 52 * D - 2);
    endtask

    task automatic wait_valid(input logic which, input string nm);
        int n = 0;
        while (!(which ? dvalid : pvalid) && n < 1000) begin
            tick();
            n++;
        end
        chk(nm, int'(which ? dvalid : pvalid), 1);
    endtask

    task automatic pulse(input logic p, input logic d);
        take_p = p;
        take_d = d;
        if (p) exp_q.push_back(0);
        if (d) exp_q.push_back(1);
        tick();
        take_p = 1'b0;
        take_d = 1'b0;
    endtask

    initial begin
        int left0, acc0, n;
        logic [4:0] dc0;
        logic p_taken, d_taken;

        apply_reset(3, 1'b0);
        check_first_draw();

        for (int i = 0; i < 52 * D - 2; i++) begin
            wait_valid(1'b0, "hist_pvalid_ready");
            pulse(1'b1, 1'b0);
            wait_valid(1'b0, "hist_refill");
        end
        for (int v = 1; v <= 10; v++) chk($sformatf("hist_value_%0d", v), hist[v], (v == 10) ? 16 * D : 4 * D);
        chk("hist_no_reshuffle", resh_cnt, 0);
        chk("hist_left_zero", cards_left, 0);

        dc0 = dcard;
        pulse(1'b1, 1'b0);
        wait_valid(1'b0, "empty_refill");
        chk("empty_reshuffle_once", resh_cnt, 1);
        chk("empty_left_after", cards_left, 52 * D - 1);
        chk("empty_dcard_kept", dcard, dc0);

        tick(); tick();
        left0 = int'(cards_left);
        pulse(1'b1, 1'b1);
        chk("both_pvalid_drop", pvalid, 0);
        chk("both_dvalid_drop", dvalid, 0);
        wait_valid(1'b0, "both_p_refill");
        chk("both_p_before_d", dvalid, 0);
        wait_valid(1'b1, "both_d_refill");
        chk("both_left_minus2", cards_left, left0 - 2);

        tick(); tick();
        left0 = int'(cards_left);
        acc0  = accepts;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        n = 0;
        while (dvalid && n < 1000) begin
            tick();
            n++;
        end
        chk("late_d_dropped", dvalid, 0);
        chk("late_d_after_p", pvalid, 1);
        wait_valid(1'b1, "late_d_refill");
        chk("late_accepts", accepts - acc0, 2);
        chk("late_left_minus2", cards_left, left0 - 2);

        p_taken = 1'b0;
        d_taken = 1'b0;
        for (int i = 0; i < 600; i++) begin
            entropy = 1'($urandom_range(0, 1));
            if (pvalid && !p_taken && $urandom_range(0, 3) == 0) begin
                take_p = 1'b1; p_taken = 1'b1; exp_q.push_back(0);
            end
            if (dvalid && !d_taken && $urandom_range(0, 3) == 0) begin
                take_d = 1'b1; d_taken = 1'b1; exp_q.push_back(1);
            end
            tick();
            take_p = 1'b0;
            take_d = 1'b0;
            if (!pvalid) p_taken = 1'b0;
            if (!dvalid) d_taken = 1'b0;
        end
        entropy = 1'b0;
        n = 0;
        while (!(pvalid && dvalid && exp_q.size() == 0) && n < 2000) begin
            tick();
            n++;
        end
        chk("random_drained", int'(pvalid && dvalid && exp_q.size() == 0), 1);

        tick(); tick();
        apply_reset(1, 1'b1);
        check_first_draw();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Upstream card source for the blackjack hand/state FSM. It keeps one pre-drawn card for the player slot and one for the dealer slot, and holds both outputs stable until the consumer takes them. It draws without replacement from a tracked shoe of DECKS×52 cards, using a 16-bit LFSR with rejection sampling. It reshuffles automatically when the shoe runs out, so the FSM never sees a value outside 1..10.

Parameters:
DECKS, 1, number of 52-card decks in the shoe; legal range 1..3, so per-rank counts fit in 4 bits.
LFSR_SEED, 16'hACE1, LFSR value loaded at reset; a seed of 0 is replaced by 16'h0001.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset_n  in  1  synchronous, active-low reset.
take_p  in  1  one-cycle pulse: consumer used pcard; refill the player slot.
take_d  in  1  one-cycle pulse: consumer used dcard; refill the dealer slot.
entropy  in  1  raw async bit (e.g. a button); double-flopped internally, then XORed into LFSR feedback.
pcard  out  5  player-slot card value, 1..10; 0 when pvalid=0.
dcard  out  5  dealer-slot card value, 1..10; 0 when dvalid=0.
pvalid  out  1  pcard holds a drawn card.
dvalid  out  1  dcard holds a drawn card.
cards_left  out  8  cards still in the shoe, excluding the two slots.
reshuffled  out  1  one-cycle pulse when the shoe is refilled.

Behaviour:
- Reset (reset_n=0 at posedge):
  - all 13 rank counters = 4*DECKS; cards_left = 52*DECKS.
  - pcard = dcard = 0; pvalid = dvalid = 0; reshuffled = 0.
  - LFSR = LFSR_SEED; state = FILL_P.
  - Reset wins over every other input in the same cycle, including mid-fill; a pending take is discarded.
- LFSR:
  - Fibonacci, advances every cycle in every state.
  - Shift left; feedback = q[15]^q[13]^q[12]^q[10]^entropy_sync.
  - Candidate rank r = q[3:0] of the current value.
- Rank to value: r=0 (Ace) -> 1; r=1..9 -> r+1; r=10..12 (J/Q/K) -> 10. No soft ace.
- States: IDLE, FILL_P, FILL_D, SHUFFLE.
- FILL_P / FILL_D, one candidate per cycle:
  - If r>=13 or count[r]==0: reject and stay.
  - Else: accept. Decrement count[r] and cards_left; load the value; set the slot's valid; go to the next state.
  - Next state: FILL_D if dvalid=0, else IDLE.
  - Latency is at least 1 cycle per card. It is unbounded but finite, because the LFSR period is 65535.
- Shoe empty: entering FILL_* with cards_left==0 goes to SHUFFLE.
  - SHUFFLE lasts one cycle: counters reload to full, cards_left = 52*DECKS, reshuffled=1, then return to the pending FILL_*.
  - Cards held in the slots are not removed from the reloaded shoe.
- IDLE:
  - take_p: pvalid<=0, pcard<=0, next FILL_P.
  - take_d: dvalid<=0, dcard<=0, next FILL_D.
  - Both in the same cycle: both slots invalidated; the player slot refills first, then the dealer slot.
- Take pulses that arrive while not in IDLE:
  - Latched into pend_p / pend_d flags.
  - A take for a slot whose valid=0 is ignored; no double consumption.
  - Flags are serviced on return to IDLE, player first.
- Fill priority is always the player slot before the dealer slot.
- Outputs are registered; pcard/dcard never change while their valid bit is 1.
- Consumer contract: sample a slot only when its valid bit is 1, and issue at most one take per valid card.

Decomposition:
- Package dealer_pkg:
  - NUM_RANKS=13; CARDS_PER_DECK=52; LFSR tap constants.
  - State enum {IDLE, FILL_P, FILL_D, SHUFFLE}.
  - Function rank_to_value(rank) returning 5 bits.
- Sub-module lfsr16: seed, entropy input, 16-bit state output. This keeps the random source swappable and separately testable.
- card_dealer holds the rank counter array, the FSM, the slots and the pending-take flags.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles, then release. pvalid=dvalid=0 and cards_left=52 during reset. Both valid bits rise within 64 cycles, player first; cards_left=50; pcard and dcard each in 1..10.
2. Full-shoe histogram (DECKS=1): 50 take_p pulses, each waiting for pvalid. Across all 52 cards drawn (50 takes plus the two held slots), value 10 appears exactly 16 times and each of 1..9 exactly 4 times. No reshuffled pulse; cards_left=0.
3. Empty refill: from test 2's end state, pulse take_p. reshuffled pulses exactly once; cards_left returns to 52, then reads 51 after the accept; dcard is unchanged throughout.
4. Simultaneous take: take_p=take_d=1 in the same cycle from IDLE. Both valid bits drop the next cycle; pvalid re-asserts before dvalid; cards_left drops by exactly 2.
5. Take during fill: pulse take_d while in FILL_P after a take_p. dvalid drops only after pvalid re-asserts. Total accepts = 2, and no card is lost from the cards_left accounting.
6. Reset mid-fill: assert reset_n=0 in the cycle of a take_p. All counters and outputs return to reset values; the LFSR reloads LFSR_SEED, and the draw sequence is identical to test 1's sequence.
